control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port clear, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port run, input, 1: permits a new fetch when high.
REQ-004 SHALL have port ir_value, input, 32: current IR contents; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-005 SHALL have port mem_ready, input, 1: memory read data valid this cycle.
REQ-006 SHALL have port bus_select, output, 32: one-hot bus source for the 32-to-5 encoder; bit 0-15 R0-R15, 16 HI, 17 LO, 18 Z_high, 19 Z_low, 20 PC, 21 MDR, 22 InPort, 23 C_sign_extended.
REQ-007 SHALL have port gpr_in, output, 16: GPR load enables, bit n loads Rn.
REQ-008 SHALL have ports Y_in, HI_in, LO_in, Z_in, PC_in, IR_in, MAR_in, MDR_in, Read, output, 1 each: register load enables and MDR memory-select; Z_in loads Z_high and Z_low together.
REQ-009 SHALL have port inc_pc, output, 1: ALU computes PC+1.
REQ-010 SHALL have port alu_op, output, 5: opcode forwarded to ALU, valid only while Z_in is high.
REQ-011 SHALL have ports done, illegal, halted, output, 1 each: instruction complete pulse, illegal-opcode pulse, halt level.

Function
REQ-012 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
REQ-013 SHALL assert at most one bus_select bit per cycle; all zero in IDLE and HALT.
REQ-014 IDLE: all outputs 0; go to T0 when run=1, else stay.
REQ-015 T0: bus_select[20], MAR_in, inc_pc, Z_in; next T1.
REQ-016 T1: bus_select[19], PC_in, Read, MDR_in; stay in T1, holding all T1 outputs, until mem_ready=1; PC_in and MDR_in SHALL be asserted only in the cycle mem_ready=1; next T2.
REQ-017 T2: bus_select[21], IR_in; next T3.
REQ-018 T3 decode (ir_value sampled this cycle): opcode 31 -> HALT with no enables; opcode 0-7 -> bus_select[Rb], Y_in, next T4; opcodes 8-30 -> illegal pulse one cycle, no enables, next IDLE.
REQ-019 T4: bus_select[Rc], Z_in, alu_op=opcode; next T5.
REQ-020 T5: bus_select[19]; opcodes 0-5 -> gpr_in[Ra], done pulse, next IDLE; opcodes 6-7 (mul, div) -> LO_in, next T6.
REQ-021 T6: bus_select[18], HI_in, done pulse; next IDLE.
REQ-022 HALT: halted=1, all enables 0; leave only via clear.
REQ-023 Opcode, Ra, Rb, Rc SHALL be latched internally in T3; T4-T6 SHALL use latched values, immune to ir_value changes.
REQ-024 Ra=Rb=Rc SHALL be legal; no special handling.
REQ-025 run deasserted mid-instruction SHALL NOT abort; sampled only in IDLE.
REQ-026 All outputs SHALL be Moore-decoded from registered state except T1 PC_in/MDR_in (qualified by mem_ready).
REQ-027 Latency without memory stall: 6 cycles T0-T5 for ALU ops, 7 for mul/div.

Reset
REQ-028 clear=1 at a clock edge SHALL force IDLE, clear latched fields, drive all outputs 0, regardless of state, including mid-T1 stall and HALT.
REQ-029 clear SHALL take priority over run and mem_ready in the same cycle.

Structure
REQ-030 Shared package SHALL hold state encoding, opcode constants (ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHL 5, MUL 6, DIV 7, HALT 31), and bus_select bit indices.
REQ-031 One sub-module, step_decoder (combinational state+fields -> control outputs), SHALL be used; the state register lives in control_sequencer.

Verification
REQ-032 clear, run=1, ir_value=ADD Ra=3 Rb=1 Rc=2, mem_ready=1 in T1 -> T0..T5 in 6 cycles; bus_select 0x100000, 0x80000, 0x200000, 0x2, 0x4, 0x80000; gpr_in=0x0008 and done in T5.
REQ-033 MUL Ra=0 Rb=5 Rc=6 -> T5 LO_in with bus_select 0x80000, T6 HI_in with bus_select 0x40000, done in T6 only, gpr_in stays 0.
REQ-034 mem_ready held low 3 cycles in T1 -> T1 held 4 cycles, Read=1 throughout, PC_in/MDR_in high only in final cycle.
REQ-035 opcode 12 -> illegal pulse in T3, no enables, returns to IDLE, next fetch starts when run=1.
REQ-036 opcode 31 -> halted=1 indefinitely with run=1; clear mid-T1 stall and in HALT -> IDLE, all outputs 0 next cycle.
REQ-037 ir_value changed during T4 -> T4/T5 selects and gpr_in follow T3-latched fields.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// control_sequencer_pkg
// Shared definitions for the instruction control sequencer:
//   - step state encoding (IDLE, T0..T6, HALT)
//   - opcode constants and opcode-class helpers
//   - bus_select bit indices for the 32-to-5 bus encoder
//   - latched instruction-field and control-output bundle types
// -----------------------------------------------------------------------------
package control_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHL  = 5'd5;
    localparam logic [4:0] OP_MUL  = 5'd6;
    localparam logic [4:0] OP_DIV  = 5'd7;
    localparam logic [4:0] OP_HALT = 5'd31;

    // bus_select bit positions; bits 0-15 select R0-R15 directly.
    localparam int BUS_HI     = 16;
    localparam int BUS_LO     = 17;
    localparam int BUS_Z_HIGH = 18;
    localparam int BUS_Z_LOW  = 19;
    localparam int BUS_PC     = 20;
    localparam int BUS_MDR    = 21;
    localparam int BUS_INPORT = 22;
    localparam int BUS_C_SIGN = 23;

    typedef struct packed {
        logic [4:0] opcode;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rc;
    } ir_fields_t;

    typedef struct packed {
        logic [31:0] bus_sel;
        logic [15:0] gpr_in;
        logic        y_in;
        logic        hi_in;
        logic        lo_in;
        logic        z_in;
        logic        pc_in;
        logic        ir_in;
        logic        mar_in;
        logic        mdr_in;
        logic        read;
        logic        inc_pc;
        logic [4:0]  alu_op;
        logic        done;
        logic        illegal;
        logic        halted;
    } ctrl_t;

    // Takes IR[31:15]: opcode, Ra, Rb, Rc packed back to back.
    function automatic ir_fields_t ir_to_fields(input logic [16:0] ir_hi);
        return ir_fields_t'(ir_hi);
    endfunction

    // Opcodes 0-7 run through the Y/Z datapath.
    function automatic logic is_alu_op(input logic [4:0] op);
        return op <= OP_DIV;
    endfunction

    // MUL/DIV produce a 64-bit result and need the extra T6 step for HI.
    function automatic logic is_wide_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/step_decoder.sv
// -----------------------------------------------------------------------------
// step_decoder
// Combinational decode of the current sequencer step plus instruction fields
// into the datapath control bundle. Outputs are a pure function of state and
// fields, except PC_in/MDR_in in T1, which wait for mem_ready.
// Ports:
//   state_i      current step from the sequencer state register
//   fields_i     instruction fields (live IR in T3, latched copy afterwards)
//   mem_ready_i  memory read data valid this cycle
//   ctrl_o       full control-output bundle
// -----------------------------------------------------------------------------
module step_decoder
    import control_sequencer_pkg::*;
(
    input  state_t     state_i,
    input  ir_fields_t fields_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        // NOTE: default every output first so no path through the case leaves
        // a signal unassigned, which would otherwise infer a latch.
        ctrl_o = '0;
        unique case (state_i)
            ST_T0: begin
                ctrl_o.bus_sel[BUS_PC] = 1'b1;
                ctrl_o.mar_in          = 1'b1;
                ctrl_o.inc_pc          = 1'b1;
                ctrl_o.z_in            = 1'b1;
            end
            ST_T1: begin
                // Read holds the MDR mux on memory for the whole stall;
                // the loads fire only once the data is valid.
                ctrl_o.bus_sel[BUS_Z_LOW] = 1'b1;
                ctrl_o.read               = 1'b1;
                ctrl_o.pc_in              = mem_ready_i;
                ctrl_o.mdr_in             = mem_ready_i;
            end
            ST_T2: begin
                ctrl_o.bus_sel[BUS_MDR] = 1'b1;
                ctrl_o.ir_in            = 1'b1;
            end
            ST_T3: begin
                if (is_alu_op(fields_i.opcode)) begin
                    ctrl_o.bus_sel[fields_i.rb] = 1'b1;
                    ctrl_o.y_in                 = 1'b1;
                end else if (fields_i.opcode != OP_HALT) begin
                    ctrl_o.illegal = 1'b1;
                end
            end
            ST_T4: begin
                ctrl_o.bus_sel[fields_i.rc] = 1'b1;
                ctrl_o.z_in                 = 1'b1;
                ctrl_o.alu_op               = fields_i.opcode;
            end
            ST_T5: begin
                ctrl_o.bus_sel[BUS_Z_LOW] = 1'b1;
                if (is_wide_op(fields_i.opcode)) begin
                    ctrl_o.lo_in = 1'b1;
                end else begin
                    ctrl_o.gpr_in[fields_i.ra] = 1'b1;
                    ctrl_o.done                = 1'b1;
                end
            end
            ST_T6: begin
                ctrl_o.bus_sel[BUS_Z_HIGH] = 1'b1;
                ctrl_o.hi_in               = 1'b1;
                ctrl_o.done                = 1'b1;
            end
            ST_HALT: begin
                ctrl_o.halted = 1'b1;
            end
            default: begin
                // IDLE: everything stays at the zero default.
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit stepping a fetch / decode / execute sequence for a
// small register machine. Fetch is T0-T2 (with a memory stall in T1), T3
// decodes and latches the instruction fields, T4-T6 execute.
// Ports:
//   clock       rising-edge clock
//   clear       synchronous active-high reset, overrides every other input
//   run         permits a new fetch; sampled only in IDLE
//   ir_value    IR contents: opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//   mem_ready   memory read data valid this cycle
//   bus_select  one-hot bus source (R0-R15, HI, LO, Zh, Zl, PC, MDR, ...)
//   gpr_in      GPR load enables, bit n loads Rn
//   Y_in .. MDR_in, Read   register load enables / MDR memory select
//   inc_pc      ALU computes PC+1
//   alu_op      opcode to the ALU, meaningful while Z_in is high
//   done        one-cycle instruction-complete pulse
//   illegal     one-cycle illegal-opcode pulse
//   halted      level, high while stopped by HALT
// -----------------------------------------------------------------------------
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir_value,
    input  logic        mem_ready,
    output logic [31:0] bus_select,
    output logic [15:0] gpr_in,
    output logic        Y_in,
    output logic        HI_in,
    output logic        LO_in,
    output logic        Z_in,
    output logic        PC_in,
    output logic        IR_in,
    output logic        MAR_in,
    output logic        MDR_in,
    output logic        Read,
    output logic        inc_pc,
    output logic [4:0]  alu_op,
    output logic        done,
    output logic        illegal,
    output logic        halted
);

    state_t     state_q;
    ir_fields_t fields_q;
    ir_fields_t fields_live;
    ir_fields_t fields_use;
    ctrl_t      ctrl;

    // Only IR[31:15] carries fields this unit decodes.
    logic unused_ir_low;
    assign unused_ir_low = ^ir_value[14:0];

    assign fields_live = ir_to_fields(ir_value[31:15]);

    // T3 decodes straight from the IR; later steps use the latched copy so
    // an IR reload during execute cannot disturb the instruction in flight.
    assign fields_use = (state_q == ST_T3) ? fields_live : fields_q;

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (clear) begin
            state_q  <= ST_IDLE;
            fields_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (run) state_q <= ST_T0;
                ST_T0:   state_q <= ST_T1;
                ST_T1:   if (mem_ready) state_q <= ST_T2;
                ST_T2:   state_q <= ST_T3;
                ST_T3: begin
                    fields_q <= fields_live;
                    if (fields_live.opcode == OP_HALT) begin
                        state_q <= ST_HALT;
                    end else if (is_alu_op(fields_live.opcode)) begin
                        state_q <= ST_T4;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_T4:   state_q <= ST_T5;
                ST_T5:   state_q <= is_wide_op(fields_q.opcode) ? ST_T6 : ST_IDLE;
                ST_T6:   state_q <= ST_IDLE;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    step_decoder u_step_decoder (
        .state_i     (state_q),
        .fields_i    (fields_use),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign bus_select = ctrl.bus_sel;
    assign gpr_in     = ctrl.gpr_in;
    assign Y_in       = ctrl.y_in;
    assign HI_in      = ctrl.hi_in;
    assign LO_in      = ctrl.lo_in;
    assign Z_in       = ctrl.z_in;
    assign PC_in      = ctrl.pc_in;
    assign IR_in      = ctrl.ir_in;
    assign MAR_in     = ctrl.mar_in;
    assign MDR_in     = ctrl.mdr_in;
    assign Read       = ctrl.read;
    assign inc_pc     = ctrl.inc_pc;
    assign alu_op     = ctrl.alu_op;
    assign done       = ctrl.done;
    assign illegal    = ctrl.illegal;
    assign halted     = ctrl.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Directed bench for control_sequencer. Each cycle the expected output bundle
// is queued together with the stimulus, then popped and compared on the
// falling edge once the outputs have settled.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    typedef struct packed {
        logic [31:0] bus;
        logic [15:0] gpr;
        logic [9:0]  en;    // {Y, HI, LO, Z, PC, IR, MAR, MDR, Read, inc_pc}
        logic [4:0]  alu;
        logic [2:0]  st;    // {done, illegal, halted}
    } outs_t;

    localparam logic [9:0] E_Y   = 10'h200;
    localparam logic [9:0] E_HI  = 10'h100;
    localparam logic [9:0] E_LO  = 10'h080;
    localparam logic [9:0] E_Z   = 10'h040;
    localparam logic [9:0] E_PC  = 10'h020;
    localparam logic [9:0] E_IR  = 10'h010;
    localparam logic [9:0] E_MAR = 10'h008;
    localparam logic [9:0] E_MDR = 10'h004;
    localparam logic [9:0] E_RD  = 10'h002;
    localparam logic [9:0] E_INC = 10'h001;

    localparam logic [2:0] S_DONE = 3'b100;
    localparam logic [2:0] S_ILL  = 3'b010;
    localparam logic [2:0] S_HALT = 3'b001;

    localparam outs_t ZERO = '0;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic [31:0] ir_value;
    logic        mem_ready;
    logic [31:0] bus_select;
    logic [15:0] gpr_in;
    logic        Y_in, HI_in, LO_in, Z_in, PC_in, IR_in, MAR_in, MDR_in, Read;
    logic        inc_pc;
    logic [4:0]  alu_op;
    logic        done, illegal, halted;

    int n_checks = 0;
    int n_fails  = 0;

    outs_t sb_q[$];
    string tag_q[$];

    control_sequencer dut (
        .clock      (clock),
        .clear      (clear),
        .run        (run),
        .ir_value   (ir_value),
        .mem_ready  (mem_ready),
        .bus_select (bus_select),
        .gpr_in     (gpr_in),
        .Y_in       (Y_in),
        .HI_in      (HI_in),
        .LO_in      (LO_in),
        .Z_in       (Z_in),
        .PC_in      (PC_in),
        .IR_in      (IR_in),
        .MAR_in     (MAR_in),
        .MDR_in     (MDR_in),
        .Read       (Read),
        .inc_pc     (inc_pc),
        .alu_op     (alu_op),
        .done       (done),
        .illegal    (illegal),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    function automatic outs_t mk(input logic [31:0] bus, input logic [15:0] gpr,
                                 input logic [9:0] en, input logic [4:0] alu,
                                 input logic [2:0] st);
        outs_t o;
        o.bus = bus;
        o.gpr = gpr;
        o.en  = en;
        o.alu = alu;
        o.st  = st;
        return o;
    endfunction

    function automatic logic [31:0] make_ir(input logic [4:0] op, input logic [3:0] ra,
                                            input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h1234};
    endfunction

    // Drive one cycle of stimulus, queue its expected outputs, compare them
    // on the falling edge, then advance past the next rising edge.
    task automatic step(input string tag, input logic c, input logic r, input logic m,
                        input logic [31:0] ir, input outs_t exp_v);
        outs_t obs;
        outs_t want;
        string t;
        clear     = c;
        run       = r;
        mem_ready = m;
        ir_value  = ir;
        sb_q.push_back(exp_v);
        tag_q.push_back(tag);
        @(negedge clock);
        obs = {bus_select, gpr_in,
               Y_in, HI_in, LO_in, Z_in, PC_in, IR_in, MAR_in, MDR_in, Read, inc_pc,
               alu_op, done, illegal, halted};
        want = sb_q.pop_front();
        t    = tag_q.pop_front();
        n_checks++;
        assert (obs === want) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", t, obs, want);
        end
        @(posedge clock);
        #1;
    endtask

    // One full ALU / MUL / DIV instruction from IDLE back to IDLE.
    // stall = cycles mem_ready stays low in T1; ir_late replaces ir_value from
    // T4 on, and the expectations still follow the original fields.
    task automatic alu_instr(input string tag, input logic [4:0] op, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [3:0] rc,
                             input int stall, input logic [31:0] ir_late);
        logic [31:0] ir;
        logic [31:0] bus_rb;
        logic [31:0] bus_rc;
        logic [15:0] gpr_ra;
        ir     = make_ir(op, ra, rb, rc);
        bus_rb = 32'h1 << rb;
        bus_rc = 32'h1 << rc;
        gpr_ra = 16'h1 << ra;
        step({tag, "_idle"}, 1'b0, 1'b1, 1'b0, ir, ZERO);
        step({tag, "_t0"},   1'b0, 1'b0, 1'b0, ir, mk(32'h0010_0000, 16'h0, E_MAR | E_INC | E_Z, 5'd0, 3'b0));
        for (int i = 0; i < stall; i++)
            step({tag, "_t1_stall"}, 1'b0, 1'b0, 1'b0, ir, mk(32'h0008_0000, 16'h0, E_RD, 5'd0, 3'b0));
        step({tag, "_t1"}, 1'b0, 1'b0, 1'b1, ir, mk(32'h0008_0000, 16'h0, E_RD | E_PC | E_MDR, 5'd0, 3'b0));
        step({tag, "_t2"}, 1'b0, 1'b0, 1'b0, ir, mk(32'h0020_0000, 16'h0, E_IR, 5'd0, 3'b0));
        step({tag, "_t3"}, 1'b0, 1'b0, 1'b0, ir, mk(bus_rb, 16'h0, E_Y, 5'd0, 3'b0));
        step({tag, "_t4"}, 1'b0, 1'b0, 1'b0, ir_late, mk(bus_rc, 16'h0, E_Z, op, 3'b0));
        if (op == 5'd6 || op == 5'd7) begin
            step({tag, "_t5"}, 1'b0, 1'b0, 1'b0, ir_late, mk(32'h0008_0000, 16'h0, E_LO, 5'd0, 3'b0));
            step({tag, "_t6"}, 1'b0, 1'b0, 1'b0, ir_late, mk(32'h0004_0000, 16'h0, E_HI, 5'd0, S_DONE));
        end else begin
            step({tag, "_t5"}, 1'b0, 1'b0, 1'b0, ir_late, mk(32'h0008_0000, gpr_ra, 10'h0, 5'd0, S_DONE));
        end
        step({tag, "_end"}, 1'b0, 1'b0, 1'b0, ir_late, ZERO);
    endtask

    initial begin
        logic [31:0] ir_add;
        logic [31:0] ir_ill;
        logic [31:0] ir_hlt;

        clear     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        ir_value  = '0;
        @(posedge clock);
        #1;

        // Reset state, with run and mem_ready high to show clear wins.
        ir_add = make_ir(5'd0, 4'd3, 4'd1, 4'd2);
        step("reset_hold", 1'b1, 1'b1, 1'b1, ir_add, ZERO);
        step("reset_idle", 1'b0, 1'b0, 1'b1, ir_add, ZERO);

        // ADD R3 = R1 + R2, memory ready immediately; run dropped after T0.
        step("add_idle", 1'b0, 1'b1, 1'b1, ir_add, ZERO);
        step("add_t0",   1'b0, 1'b0, 1'b1, ir_add, mk(32'h0010_0000, 16'h0, E_MAR | E_INC | E_Z, 5'd0, 3'b0));
        step("add_t1",   1'b0, 1'b0, 1'b1, ir_add, mk(32'h0008_0000, 16'h0, E_RD | E_PC | E_MDR, 5'd0, 3'b0));
        step("add_t2",   1'b0, 1'b0, 1'b1, ir_add, mk(32'h0020_0000, 16'h0, E_IR, 5'd0, 3'b0));
        step("add_t3",   1'b0, 1'b0, 1'b1, ir_add, mk(32'h0000_0002, 16'h0, E_Y, 5'd0, 3'b0));
        step("add_t4",   1'b0, 1'b0, 1'b1, ir_add, mk(32'h0000_0004, 16'h0, E_Z, 5'd0, 3'b0));
        step("add_t5",   1'b0, 1'b0, 1'b1, ir_add, mk(32'h0008_0000, 16'h0008, 10'h0, 5'd0, S_DONE));
        step("add_idle_after", 1'b0, 1'b0, 1'b1, ir_add, ZERO);

        // MUL R0 = R5 * R6: LO in T5, HI in T6, done only in T6.
        alu_instr("mul", 5'd6, 4'd0, 4'd5, 4'd6, 0, make_ir(5'd6, 4'd0, 4'd5, 4'd6));

        // SUB with Ra=Rb=Rc and a three-cycle memory stall.
        alu_instr("sub_stall", 5'd1, 4'd7, 4'd7, 4'd7, 3, make_ir(5'd1, 4'd7, 4'd7, 4'd7));

        // OR at the register-index extremes.
        alu_instr("or_edge", 5'd3, 4'd15, 4'd14, 4'd0, 0, make_ir(5'd3, 4'd15, 4'd14, 4'd0));

        // DIV: second wide opcode.
        alu_instr("div", 5'd7, 4'd9, 4'd10, 4'd11, 1, make_ir(5'd7, 4'd9, 4'd10, 4'd11));

        // ADD whose IR changes from T4 on; execute must use the T3 fields.
        alu_instr("add_irchg", 5'd0, 4'd3, 4'd1, 4'd2, 0, make_ir(5'd5, 4'd9, 4'd10, 4'd11));

        // Illegal opcode 12: single pulse in T3, then back to IDLE.
        ir_ill = make_ir(5'd12, 4'd1, 4'd2, 4'd3);
        step("ill_idle", 1'b0, 1'b1, 1'b1, ir_ill, ZERO);
        step("ill_t0",   1'b0, 1'b1, 1'b1, ir_ill, mk(32'h0010_0000, 16'h0, E_MAR | E_INC | E_Z, 5'd0, 3'b0));
        step("ill_t1",   1'b0, 1'b1, 1'b1, ir_ill, mk(32'h0008_0000, 16'h0, E_RD | E_PC | E_MDR, 5'd0, 3'b0));
        step("ill_t2",   1'b0, 1'b1, 1'b1, ir_ill, mk(32'h0020_0000, 16'h0, E_IR, 5'd0, 3'b0));
        step("ill_t3",   1'b0, 1'b0, 1'b1, ir_ill, mk(32'h0, 16'h0, 10'h0, 5'd0, S_ILL));
        step("ill_idle_after", 1'b0, 1'b1, 1'b0, ir_ill, ZERO);

        // Next fetch starts; clear lands during a T1 stall.
        step("refetch_t0",  1'b0, 1'b0, 1'b0, ir_add, mk(32'h0010_0000, 16'h0, E_MAR | E_INC | E_Z, 5'd0, 3'b0));
        step("stall_t1",    1'b0, 1'b0, 1'b0, ir_add, mk(32'h0008_0000, 16'h0, E_RD, 5'd0, 3'b0));
        step("clear_in_t1", 1'b1, 1'b1, 1'b1, ir_add, mk(32'h0008_0000, 16'h0, E_RD | E_PC | E_MDR, 5'd0, 3'b0));
        step("after_clear_t1", 1'b0, 1'b0, 1'b1, ir_add, ZERO);

        // HALT: T3 with no enables, then halted holds despite run=1.
        ir_hlt = make_ir(5'd31, 4'd0, 4'd0, 4'd0);
        step("hlt_idle", 1'b0, 1'b1, 1'b1, ir_hlt, ZERO);
        step("hlt_t0",   1'b0, 1'b1, 1'b1, ir_hlt, mk(32'h0010_0000, 16'h0, E_MAR | E_INC | E_Z, 5'd0, 3'b0));
        step("hlt_t1",   1'b0, 1'b1, 1'b1, ir_hlt, mk(32'h0008_0000, 16'h0, E_RD | E_PC | E_MDR, 5'd0, 3'b0));
        step("hlt_t2",   1'b0, 1'b1, 1'b1, ir_hlt, mk(32'h0020_0000, 16'h0, E_IR, 5'd0, 3'b0));
        step("hlt_t3",   1'b0, 1'b1, 1'b1, ir_hlt, ZERO);
        for (int i = 0; i < 4; i++)
            step("halted", 1'b0, 1'b1, 1'b1, ir_add, mk(32'h0, 16'h0, 10'h0, 5'd0, S_HALT));
        step("clear_in_halt", 1'b1, 1'b1, 1'b1, ir_add, mk(32'h0, 16'h0, 10'h0, 5'd0, S_HALT));
        step("after_clear_halt", 1'b0, 1'b0, 1'b1, ir_add, ZERO);

        // Normal operation resumes after leaving HALT.
        alu_instr("shl_resume", 5'd5, 4'd2, 4'd4, 4'd8, 0, make_ir(5'd5, 4'd2, 4'd4, 4'd8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
